mem_rd_arbiter: RTL

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

---
 rtl/mem_rd_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - shared read-port arbiter for fetch and data read requests
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, data priority with fetch anti-starvation.
module mem_rd_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_instr,
  output logic        if_error,
  input  logic        d_req,
  input  logic [63:0] d_addr,
  output logic        d_resp_valid,
  output logic [63:0] d_data,
  output logic        d_error,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_error
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 1: data owns the transaction, 0: fetch
  logic          sel_q, sel_d;
  logic [63:0]   addr_q, addr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [31:0]   if_instr_q, if_instr_d;
  logic          if_error_q, if_error_d;
  logic [63:0]   d_data_q, d_data_d;
  logic          d_error_q, d_error_d;

  logic          grant_fetch;
  logic          rsp_done;
  logic [63:0]   rsp_data;
  logic          rsp_err;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    starve_d    = starve_q;
    wcnt_d      = wcnt_q;
    if_instr_d  = if_instr_q;
    if_error_d  = if_error_q;
    d_data_d    = d_data_q;
    d_error_d   = d_error_q;
    grant_fetch = 1'b0;
    // A timeout looks like a response carrying zero data and an error flag.
    rsp_done    = mem_resp_valid || (wcnt_q == WAIT_LAST);
    rsp_data    = mem_resp_valid ? mem_rdata : 64'd0;
    rsp_err     = mem_resp_valid ? mem_error : 1'b1;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          grant_fetch = if_req && (!d_req || (starve_q == STARVE_MAX));
          owner_d     = !grant_fetch;
          if (grant_fetch) begin
            sel_d    = if_addr[2];
            addr_d   = {if_addr[63:3], 3'b000};
            starve_d = '0;
          end else begin
            sel_d  = d_addr[2];
            addr_d = {d_addr[63:3], 3'b000};
            if (!if_req) begin
              starve_d = '0;
            end else if (starve_q != STARVE_MAX) begin
              starve_d = starve_q + SW'(1);
            end
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_done) begin
          if (owner_q) begin
            d_data_d  = rsp_data;
            d_error_d = rsp_err;
          end else begin
            if_instr_d = sel_q ? rsp_data[63:32] : rsp_data[31:0];
            if_error_d = rsp_err;
          end
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      starve_q   <= '0;
      wcnt_q     <= '0;
      if_instr_q <= '0;
      if_error_q <= 1'b0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      starve_q   <= starve_d;
      wcnt_q     <= wcnt_d;
      if_instr_q <= if_instr_d;
      if_error_q <= if_error_d;
      d_data_q   <= d_data_d;
      d_error_q  <= d_error_d;
    end
  end

  assign mem_req       = (state_q == S_ISSUE);
  assign mem_addr      = addr_q;
  assign if_resp_valid = (state_q == S_RESP) && !owner_q;
  assign d_resp_valid  = (state_q == S_RESP) && owner_q;
  assign if_instr      = if_instr_q;
  assign if_error      = if_error_q;
  assign d_data        = d_data_q;
  assign d_error       = d_error_q;

endmodule
